// File: rtl/out_capture_fifo.sv
// Capture FIFO for CPU output words: buffers up to DEPTH show-ahead entries, stops
// accepting after MAXCOUNT words and reports done once the buffer has drained.
module out_capture_fifo #(
    parameter int DATAWIDTH = 25,
    parameter int DEPTH     = 16,
    parameter int MAXCOUNT  = 2500
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     outFlag,
    input  logic [DATAWIDTH-1:0]     out,
    input  logic                     rdReady,
    output logic                     rdValid,
    output logic [DATAWIDTH-1:0]     rdData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [15:0]              captured,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [15:0] LAST_WORD = 16'(MAXCOUNT - 1);

    typedef enum logic [1:0] {CAPTURE, DRAIN, FINISHED} state_t;

    state_t               state_reg, state_next;
    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]          count_reg, count_next;
    logic [15:0]          captured_reg;
    logic                 overflow_reg;
    logic                 push, pop, drop;

    assign full    = (count_reg == DEPTH_C);
    assign rdValid = (count_reg != '0);
    assign pop     = rdValid && rdReady;
    assign push    = outFlag && (state_reg == CAPTURE) && (!full || pop);
    assign drop    = outFlag && (state_reg == CAPTURE) && full && !pop;

    assign count_next = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // Storage is deliberately left out of reset; it is unobservable while empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= out;
        end
    end

    assign rdData = mem[rd_ptr_reg];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            captured_reg <= '0;
            overflow_reg <= 1'b0;
            state_reg    <= CAPTURE;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + AW'(1);
                captured_reg <= captured_reg + 16'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            count_reg <= count_next;
            state_reg <= state_next;
        end
    end

    // Drain completes on the edge where occupancy (after this cycle's pop) reaches zero.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CAPTURE:  if (push && captured_reg == LAST_WORD) state_next = DRAIN;
            DRAIN:    if (count_next == '0) state_next = FINISHED;
            FINISHED: state_next = FINISHED;
            default:  state_next = CAPTURE;
        endcase
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign captured = captured_reg;
    assign done     = (state_reg == FINISHED);

endmodule

// File: tb/tb_out_capture_fifo.sv
// Scoreboard bench for out_capture_fifo: a default instance and a MAXCOUNT=4 instance
// share stimulus; each has its own queue-based reference model checked every cycle.
module tb_out_capture_fifo;

    localparam int DW    = 25;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset, outFlag, rdReady;
    logic [DW-1:0] out;

    logic          rdValid, full, overflow, done;
    logic [DW-1:0] rdData;
    logic [4:0]    count;
    logic [15:0]   captured;
    logic          rdValid_m, full_m, overflow_m, done_m;
    logic [DW-1:0] rdData_m;
    logic [4:0]    count_m;
    logic [15:0]   captured_m;

    out_capture_fifo #(.DATAWIDTH(DW), .DEPTH(DEPTH), .MAXCOUNT(2500)) dut (
        .clock(clock), .reset(reset), .outFlag(outFlag), .out(out), .rdReady(rdReady),
        .rdValid(rdValid), .rdData(rdData), .count(count), .full(full),
        .overflow(overflow), .captured(captured), .done(done)
    );

    out_capture_fifo #(.DATAWIDTH(DW), .DEPTH(DEPTH), .MAXCOUNT(4)) dut_m (
        .clock(clock), .reset(reset), .outFlag(outFlag), .out(out), .rdReady(rdReady),
        .rdValid(rdValid_m), .rdData(rdData_m), .count(count_m), .full(full_m),
        .overflow(overflow_m), .captured(captured_m), .done(done_m)
    );

    always #5 clock = ~clock;

    logic [1:0]         rdv, fl, ovf, dn;
    logic [1:0][DW-1:0] rdd;
    logic [1:0][4:0]    cnt;
    logic [1:0][15:0]   cap;
    assign rdv = {rdValid_m, rdValid};
    assign fl  = {full_m, full};
    assign ovf = {overflow_m, overflow};
    assign dn  = {done_m, done};
    assign rdd[0] = rdData;
    assign rdd[1] = rdData_m;
    assign cnt[0] = count;
    assign cnt[1] = count_m;
    assign cap[0] = captured;
    assign cap[1] = captured_m;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model, one per instance: 0 = CAPTURE, 1 = DRAIN, 2 = FINISHED
    int            m_max [2] = '{2500, 4};
    int            m_cap [2];
    bit            m_ovf [2];
    int            m_st  [2];
    logic [DW-1:0] m_q   [2][$];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k].delete();
            m_cap[k] = 0;
            m_ovf[k] = 1'b0;
            m_st[k]  = 0;
        end
    endtask

    task automatic check_state();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rdValid%0d", k), 32'(rdv[k]), 32'(m_q[k].size() != 0));
            chk($sformatf("count%0d", k), 32'(cnt[k]), 32'(m_q[k].size()));
            chk($sformatf("full%0d", k), 32'(fl[k]), 32'(m_q[k].size() == DEPTH));
            chk($sformatf("overflow%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
            chk($sformatf("captured%0d", k), 32'(cap[k]), 32'(m_cap[k]));
            chk($sformatf("done%0d", k), 32'(dn[k]), 32'(m_st[k] == 2));
        end
    endtask

    // One clock cycle: check registered state, drive inputs, check the head word on pops.
    task automatic step(input logic f, input logic [DW-1:0] d, input logic rr);
        bit pop, push, is_full, in_cap;
        check_state();
        outFlag = f;
        out     = d;
        rdReady = rr;
        #1;
        for (int k = 0; k < 2; k++) begin
            pop     = (m_q[k].size() != 0) && rr;
            is_full = (m_q[k].size() == DEPTH);
            in_cap  = (m_st[k] == 0);
            push    = f && in_cap && (!is_full || pop);
            if (f && in_cap && is_full && !pop) m_ovf[k] = 1'b1;
            if (pop) begin
                chk($sformatf("rdData%0d", k), 32'(rdd[k]), 32'(m_q[k][0]));
                if (k == 0) $display("pop dut%0d data=0x%07h", k, rdd[k]);
                void'(m_q[k].pop_front());
            end
            if (push) begin
                m_q[k].push_back(d);
                m_cap[k]++;
            end
            if (in_cap && push && m_cap[k] == m_max[k]) m_st[k] = 1;
            else if (m_st[k] == 1 && m_q[k].size() == 0) m_st[k] = 2;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        outFlag = 1'b0;
        rdReady = 1'b0;
        out     = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        outFlag = 1'b0;
        rdReady = 1'b0;
        out     = '0;
        model_reset();
        do_reset();

        // Three words streamed with a ready consumer
        step(1'b1, 25'h0000001, 1'b1);
        step(1'b1, 25'h0000002, 1'b1);
        step(1'b1, 25'h0000003, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("captured_after_3", 32'(captured), 32'd3);

        // Fill, push+pop at full, then a dropped word
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, DW'(32'h100 + i), 1'b0);
        chk("full_at_16", 32'(full), 32'd1);
        step(1'b1, 25'h1ABCDE, 1'b1);
        chk("no_ovf_push_pop_full", 32'(overflow), 32'd0);
        step(1'b1, 25'h1FFFFF, 1'b0);
        chk("ovf_after_drop", 32'(overflow), 32'd1);
        chk("captured_16_plus_1", 32'(captured), 32'd17);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);

        // Build count=5 with overflow set, then reset between edges
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
        check_state();
        chk("pre_reset_count", 32'(count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_rdValid%0d", k), 32'(rdv[k]), 32'd0);
            chk($sformatf("async_count%0d", k), 32'(cnt[k]), 32'd0);
            chk($sformatf("async_full%0d", k), 32'(fl[k]), 32'd0);
            chk($sformatf("async_overflow%0d", k), 32'(ovf[k]), 32'd0);
            chk($sformatf("async_captured%0d", k), 32'(cap[k]), 32'd0);
            chk($sformatf("async_done%0d", k), 32'(dn[k]), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // MAXCOUNT=4 instance: six pulses, only four captured, then drain to done
        for (int i = 0; i < 6; i++) step(1'b1, DW'(i + 1), 1'b0);
        chk("mc_captured", 32'(captured_m), 32'd4);
        chk("mc_overflow", 32'(overflow_m), 32'd0);
        chk("mc_count", 32'(count_m), 32'd4);
        for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h50 + i), 1'b1);
        chk("mc_done_before_last_pop", 32'(done_m), 32'd0);
        step(1'b0, '0, 1'b1);
        chk("mc_done_after_last_pop", 32'(done_m), 32'd1);
        chk("mc_captured_frozen", 32'(captured_m), 32'd4);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // Pointer wrap: 40 words, rdReady toggling every cycle
        do_reset();
        for (int i = 0; i < 80; i++) step(i[0] == 1'b0, DW'($urandom), i[0]);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);
        check_state();
        chk("wrap_overflow", 32'(overflow), 32'd0);
        chk("wrap_captured", 32'(captured), 32'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/out_capture_fifo.md
OUT_CAPTURE_FIFO -- requirements
Module: out_capture_fifo

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 25, width of captured CPU output word.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter MAXCOUNT, default 2500, number of words captured before stop.
REQ-004 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port outFlag  input  1  CPU output-valid strobe, one word per high cycle.
REQ-007 SHALL have port out  input  DATAWIDTH  CPU output word, sampled when outFlag=1.
REQ-008 SHALL have port rdReady  input  1  downstream consumer accepts rdData this cycle.
REQ-009 SHALL have port rdValid  output  1  FIFO non-empty, rdData valid.
REQ-010 SHALL have port rdData  output  DATAWIDTH  oldest stored word (show-ahead).
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: a word was dropped.
REQ-014 SHALL have port captured  output  16  words accepted since reset.
REQ-015 SHALL have port done  output  1  MAXCOUNT words captured and FIFO fully drained.

Function
REQ-016 SHALL implement a circular buffer of DEPTH entries with wrapping read/write pointers; pointers wrap DEPTH-1 -> 0.
REQ-017 SHALL define push = outFlag and state==CAPTURE and (not full or pop); pop = rdValid and rdReady.
REQ-018 SHALL write out into the buffer on the clock edge where push=1; word visible on rdData with rdValid=1 from the next cycle (no same-cycle bypass).
REQ-019 SHALL drive rdData combinationally from the entry at the read pointer; rdData value when rdValid=0 is don't-care.
REQ-020 SHALL advance the read pointer on the edge where pop=1; rdReady with rdValid=0 has no effect.
REQ-021 SHALL on simultaneous push and pop keep count unchanged, including when full (push accepted) and when count=1.
REQ-022 SHALL, when outFlag=1 in CAPTURE with full=1 and pop=0, drop the word, leave FIFO unchanged, set overflow=1 next cycle; overflow holds until reset.
REQ-023 SHALL increment captured by 1 per accepted push; dropped words not counted.
REQ-024 SHALL implement FSM states CAPTURE, DRAIN, FINISHED.
REQ-025 SHALL transition CAPTURE -> DRAIN on the edge where the push makes captured reach MAXCOUNT.
REQ-026 SHALL in DRAIN and FINISHED ignore outFlag completely: no push, no overflow, captured frozen at MAXCOUNT.
REQ-027 SHALL transition DRAIN -> FINISHED on the first edge where count==0 (after any pop that cycle); FINISHED is terminal until reset.
REQ-028 SHALL assert done=1 only in FINISHED.
REQ-029 SHALL keep captured width 16 bits; MAXCOUNT <= 65535.

Reset
REQ-030 SHALL on reset=1 immediately (asynchronously) clear pointers, count=0, rdValid=0, full=0, overflow=0, captured=0, done=0, state=CAPTURE.
REQ-031 SHALL not clear buffer storage on reset; storage contents unobservable while rdValid=0.
REQ-032 SHALL, on reset asserted mid-operation (any state), discard all stored words and resume in CAPTURE on the first edge after deassertion.

Verification
REQ-033 SHALL cover: reset, outFlag pulses with out=0x0000001,0x0000002,0x0000003, rdReady=1 -> rdData 1,2,3 in order, each rdValid one cycle after its push, captured=3.
REQ-034 SHALL cover: rdReady=0, 17 outFlag pulses with DEPTH=16 -> full=1 after 16th, count=16, 17th dropped, overflow=1, captured=16.
REQ-035 SHALL cover: FIFO full, outFlag=1 and rdReady=1 same cycle -> count stays 16, no overflow, new word read out last.
REQ-036 SHALL cover: MAXCOUNT=4, rdReady=0, 6 pulses -> captured=4, state DRAIN, no overflow; then rdReady=1 -> 4 words popped, done=1 on the edge count hits 0.
REQ-037 SHALL cover: reset asserted between clock edges with count=5 and overflow=1 -> all outputs zero immediately, before the next clock edge.
REQ-038 SHALL cover: pointer wrap, 40 words streamed with rdReady toggling every cycle -> output sequence equals input sequence, no overflow.
